rcu_wb_collector: RTL



---
 rtl/rcu_wb_collector_if.sv | 67 ++++++
 rtl/rcu_wb_collector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rcu_wb_collector_if.sv
// Writeback collector bus: FU responses, ROB head and flush in; merged writeback
// ports, issue stall and PC redirect out.
interface rcu_wb_collector_if #(
  parameter int XLEN               = 64,
  parameter int ROB_INDEX_WIDTH    = 4,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int PC_WIDTH           = 39
);
  logic                          fu_rcu_alu1_resp_valid_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rcu_alu1_wrb_rob_index_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_rcu_alu1_wrb_prd_addr_i;
  logic [XLEN-1:0]               fu_rcu_alu1_wrb_data_i;
  logic                          fu_rcu_alu1_branch_predict_miss_i;
  logic [PC_WIDTH-1:0]           fu_rcu_alu1_final_next_pc_i;

  logic                          fu_rcu_alu2_resp_valid_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rcu_alu2_wrb_rob_index_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_rcu_alu2_wrb_prd_addr_i;
  logic [XLEN-1:0]               fu_rcu_alu2_wrb_data_i;
  logic                          fu_rcu_alu2_branch_predict_miss_i;
  logic [PC_WIDTH-1:0]           fu_rcu_alu2_final_next_pc_i;

  logic                          fu_rcu_lsu_comm_vld_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rcu_lsu_comm_rob_index_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_rcu_lsu_comm_rd_addr_i;
  logic [XLEN-1:0]               fu_rcu_lsu_comm_data_i;

  logic [ROB_INDEX_WIDTH-1:0]    rob_head_i;
  logic                          flush_i;

  logic                          wb0_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]    wb0_rob_index_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb0_prd_addr_o;
  logic [XLEN-1:0]               wb0_data_o;
  logic                          wb1_vld_o;
  logic [ROB_INDEX_WIDTH-1:0]    wb1_rob_index_o;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb1_prd_addr_o;
  logic [XLEN-1:0]               wb1_data_o;
  logic                          wb_stall_o;
  logic                          redirect_vld_o;
  logic [PC_WIDTH-1:0]           redirect_pc_o;
  logic [ROB_INDEX_WIDTH-1:0]    redirect_rob_index_o;

  modport master (
    output fu_rcu_alu1_resp_valid_i, fu_rcu_alu1_wrb_rob_index_i, fu_rcu_alu1_wrb_prd_addr_i,
           fu_rcu_alu1_wrb_data_i, fu_rcu_alu1_branch_predict_miss_i, fu_rcu_alu1_final_next_pc_i,
           fu_rcu_alu2_resp_valid_i, fu_rcu_alu2_wrb_rob_index_i, fu_rcu_alu2_wrb_prd_addr_i,
           fu_rcu_alu2_wrb_data_i, fu_rcu_alu2_branch_predict_miss_i, fu_rcu_alu2_final_next_pc_i,
           fu_rcu_lsu_comm_vld_i, fu_rcu_lsu_comm_rob_index_i, fu_rcu_lsu_comm_rd_addr_i,
           fu_rcu_lsu_comm_data_i, rob_head_i, flush_i,
    input  wb0_vld_o, wb0_rob_index_o, wb0_prd_addr_o, wb0_data_o,
           wb1_vld_o, wb1_rob_index_o, wb1_prd_addr_o, wb1_data_o,
           wb_stall_o, redirect_vld_o, redirect_pc_o, redirect_rob_index_o
  );

  modport slave (
    input  fu_rcu_alu1_resp_valid_i, fu_rcu_alu1_wrb_rob_index_i, fu_rcu_alu1_wrb_prd_addr_i,
           fu_rcu_alu1_wrb_data_i, fu_rcu_alu1_branch_predict_miss_i, fu_rcu_alu1_final_next_pc_i,
           fu_rcu_alu2_resp_valid_i, fu_rcu_alu2_wrb_rob_index_i, fu_rcu_alu2_wrb_prd_addr_i,
           fu_rcu_alu2_wrb_data_i, fu_rcu_alu2_branch_predict_miss_i, fu_rcu_alu2_final_next_pc_i,
           fu_rcu_lsu_comm_vld_i, fu_rcu_lsu_comm_rob_index_i, fu_rcu_lsu_comm_rd_addr_i,
           fu_rcu_lsu_comm_data_i, rob_head_i, flush_i,
    output wb0_vld_o, wb0_rob_index_o, wb0_prd_addr_o, wb0_data_o,
           wb1_vld_o, wb1_rob_index_o, wb1_prd_addr_o, wb1_data_o,
           wb_stall_o, redirect_vld_o, redirect_pc_o, redirect_rob_index_o
  );
endinterface

// File: rtl/rcu_wb_collector.sv
// Merges up to three writebacks per cycle onto two registered ports with an
// in-order overflow FIFO, and raises one redirect for the oldest mispredict.
module rcu_wb_collector #(
  parameter int XLEN               = 64,
  parameter int ROB_INDEX_WIDTH    = 4,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int PC_WIDTH           = 39,
  parameter int BUF_DEPTH          = 4,
  parameter int BUF_PTR_WIDTH      = 2
) (
  input  logic               clk,
  input  logic               rstn,
  rcu_wb_collector_if.slave  bus
);
  localparam int CNT_W = BUF_PTR_WIDTH + 1;

  typedef struct packed {
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    logic [XLEN-1:0]               data;
  } wb_entry_t;

  typedef enum logic {RD_IDLE, RD_WAIT_FLUSH} rd_state_e;

  wb_entry_t                buf_q [BUF_DEPTH];
  logic [BUF_PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  wb_entry_t cand [5];
  logic [4:0] cand_vld;
  wb_entry_t slot [5];
  logic [4:0] slot_vld;
  logic [1:0] deq_cnt, enq_cnt;

  wb_entry_t wb0_q, wb1_q;
  logic      wb0_vld_q, wb1_vld_q, stall_q;

  rd_state_e                  state_q, state_d;
  logic                       redir_fire;
  logic                       redir_vld_q;
  logic [PC_WIDTH-1:0]        redir_pc_q, sel_pc;
  logic [ROB_INDEX_WIDTH-1:0] redir_rob_q, sel_rob;
  logic                       miss1, miss2;
  logic [ROB_INDEX_WIDTH-1:0] age1, age2;

  // Candidates in age order: the two oldest FIFO entries, then alu1, alu2, lsu.
  always_comb begin
    cand[0]     = buf_q[head_q];
    cand_vld[0] = (count_q != '0);
    cand[1]     = buf_q[head_q + BUF_PTR_WIDTH'(1)];
    cand_vld[1] = (count_q > CNT_W'(1));
    cand[2]     = '{rob: bus.fu_rcu_alu1_wrb_rob_index_i, prd: bus.fu_rcu_alu1_wrb_prd_addr_i,
                    data: bus.fu_rcu_alu1_wrb_data_i};
    cand_vld[2] = bus.fu_rcu_alu1_resp_valid_i;
    cand[3]     = '{rob: bus.fu_rcu_alu2_wrb_rob_index_i, prd: bus.fu_rcu_alu2_wrb_prd_addr_i,
                    data: bus.fu_rcu_alu2_wrb_data_i};
    cand_vld[3] = bus.fu_rcu_alu2_resp_valid_i;
    cand[4]     = '{rob: bus.fu_rcu_lsu_comm_rob_index_i, prd: bus.fu_rcu_lsu_comm_rd_addr_i,
                    data: bus.fu_rcu_lsu_comm_data_i};
    cand_vld[4] = bus.fu_rcu_lsu_comm_vld_i;
  end

  // Compact valid candidates: slots 0/1 feed wb0/wb1, slots 2..4 are enqueued.
  // FIFO entries sit at the front, so only incoming responses reach slots 2..4.
  always_comb begin : compact
    logic [2:0] n;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    n        = '0;
    slot_vld = '0;
    for (int i = 0; i < 5; i++) slot[i] = '0;
    for (int k = 0; k < 5; k++) begin
      if (cand_vld[k]) begin
        slot[n]     = cand[k];
        slot_vld[n] = 1'b1;
        n           = n + 3'd1;
      end
    end
  end

  always_comb begin
    deq_cnt = (count_q > CNT_W'(1)) ? 2'd2 : {1'b0, (count_q != '0)};
    enq_cnt = {1'b0, slot_vld[2]} + {1'b0, slot_vld[3]} + {1'b0, slot_vld[4]};
    head_d  = head_q + BUF_PTR_WIDTH'(deq_cnt);
    tail_d  = tail_q + BUF_PTR_WIDTH'(enq_cnt);
    count_d = count_q + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);
  end

  assign miss1 = bus.fu_rcu_alu1_resp_valid_i & bus.fu_rcu_alu1_branch_predict_miss_i;
  assign miss2 = bus.fu_rcu_alu2_resp_valid_i & bus.fu_rcu_alu2_branch_predict_miss_i;
  assign age1  = bus.fu_rcu_alu1_wrb_rob_index_i - bus.rob_head_i;
  assign age2  = bus.fu_rcu_alu2_wrb_rob_index_i - bus.rob_head_i;

  always_comb begin
    state_d    = state_q;
    redir_fire = 1'b0;
    sel_pc     = bus.fu_rcu_alu1_final_next_pc_i;
    sel_rob    = bus.fu_rcu_alu1_wrb_rob_index_i;
    if (miss2 && (!miss1 || (age2 < age1))) begin
      sel_pc  = bus.fu_rcu_alu2_final_next_pc_i;
      sel_rob = bus.fu_rcu_alu2_wrb_rob_index_i;
    end
    case (state_q)
      RD_IDLE: begin
        if (miss1 || miss2) begin
          redir_fire = 1'b1;
          state_d    = RD_WAIT_FLUSH;
        end
      end
      RD_WAIT_FLUSH: state_d = RD_WAIT_FLUSH;
      default:       state_d = RD_IDLE;
    endcase
    if (bus.flush_i) begin
      redir_fire = 1'b0;
      state_d    = RD_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wb0_q       <= '0;
      wb1_q       <= '0;
      wb0_vld_q   <= 1'b0;
      wb1_vld_q   <= 1'b0;
      stall_q     <= 1'b0;
      state_q     <= RD_IDLE;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= '0;
      redir_rob_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_vld_q <= redir_fire;
      if (redir_fire) begin
        redir_pc_q  <= sel_pc;
        redir_rob_q <= sel_rob;
      end
      if (bus.flush_i) begin
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
        wb0_vld_q <= 1'b0;
        wb1_vld_q <= 1'b0;
        stall_q   <= 1'b0;
      end else begin
        head_q    <= head_d;
        tail_q    <= tail_d;
        count_q   <= count_d;
        wb0_q     <= slot[0];
        wb1_q     <= slot[1];
        wb0_vld_q <= slot_vld[0];
        wb1_vld_q <= slot_vld[1];
        stall_q   <= (count_d >= CNT_W'(BUF_DEPTH - 2));
      end
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone says which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (int'(enq_cnt) > i) buf_q[tail_q + BUF_PTR_WIDTH'(i)] <= slot[2 + i];
    end
  end

  assign bus.wb0_vld_o            = wb0_vld_q;
  assign bus.wb0_rob_index_o      = wb0_q.rob;
  assign bus.wb0_prd_addr_o       = wb0_q.prd;
  assign bus.wb0_data_o           = wb0_q.data;
  assign bus.wb1_vld_o            = wb1_vld_q;
  assign bus.wb1_rob_index_o      = wb1_q.rob;
  assign bus.wb1_prd_addr_o       = wb1_q.prd;
  assign bus.wb1_data_o           = wb1_q.data;
  assign bus.wb_stall_o           = stall_q;
  assign bus.redirect_vld_o       = redir_vld_q;
  assign bus.redirect_pc_o        = redir_pc_q;
  assign bus.redirect_rob_index_o = redir_rob_q;
endmodule
